act_unit: RTL and testbench

ACT_UNIT -- requirements
Module: act_unit

---
 rtl/tpu_pkg.sv | 18 +
 rtl/act_requant.sv | 43 ++++
 rtl/act_unit.sv | 117 +++++++++++
 tb/tb_act_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath blocks.
// Holds accumulator/activation element types, the shift-amount width
// and the act_unit FSM state encoding.
package tpu_pkg;

  typedef logic signed [31:0] acc_t;
  typedef logic signed [7:0]  act_t;

  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2,
    OUT  = 2'd3
  } act_state_t;

endpackage

// File: rtl/act_requant.sv
// Single-element requantizer: round-half-up right shift of a 32-bit
// accumulator, then saturation to the 8-bit activation range.
// Build option: define ACT_UNIT_RELU_EN to clamp negative results to zero
// (applied after rounding, before saturation).
module act_requant
  import tpu_pkg::*;
(
  input  acc_t               x,
  input  logic [SHIFT_W-1:0] shift,
  output act_t               y
);

  // 33 bits leaves headroom so adding the rounding constant to the most
  // positive accumulator cannot wrap.
  logic signed [32:0] ext;
  logic signed [32:0] rnd;
  logic signed [32:0] sum;
  logic signed [32:0] r;

  // Round (add half an LSB of the result), arithmetic shift, clamp.
  always_comb begin
    ext = {x[31], x};
    rnd = '0;
    if (shift != '0) begin
      rnd = 33'sd1 <<< (shift - 1'b1);
    end
    sum = ext + rnd;
    r   = sum >>> shift;
`ifdef ACT_UNIT_RELU_EN
    if (r < 0) begin
      r = '0;
    end
`endif
    if (r > 33'sd127) begin
      y = 8'sd127;
    end else if (r < -33'sd128) begin
      y = -8'sd128;
    end else begin
      y = r[7:0];
    end
  end

endmodule

// File: rtl/act_unit.sv
// Activation unit: pops one SIZExSIZE accumulator matrix from the mmu
// result FIFO, requantizes it one row per cycle and presents the 8-bit
// matrix downstream with a valid/ready handshake.
// Build option: ACT_UNIT_RELU_EN enables ReLU inside act_requant.
//
// Handshakes:
//   upstream   - acc_out is valid whenever acc_out_rdy is high (show-ahead);
//                acc_out_pop is a one-cycle strobe that consumes the head
//                entry, issued only from POP.
//   downstream - act_out is stable while act_out_valid is high; a transfer
//                happens on a rising edge where act_out_valid && act_out_ready.
module act_unit
  import tpu_pkg::*;
#(
  parameter int SIZE = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             acc_out_rdy,
  input  logic [SIZE-1:0][SIZE-1:0][31:0]  acc_out,
  output logic                             acc_out_pop,
  input  logic [4:0]                       shift,
  output logic [SIZE-1:0][SIZE-1:0][7:0]   act_out,
  output logic                             act_out_valid,
  input  logic                             act_out_ready,
  output logic                             busy,
  output logic [1:0]                       state_dbg
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  act_state_t                       state_q;
  act_state_t                       state_d;
  logic [ROW_W-1:0]                 row_q;
  logic [SIZE-1:0][SIZE-1:0][31:0]  cap_q;
  logic [SHIFT_W-1:0]               shift_q;
  logic [SIZE-1:0][SIZE-1:0][7:0]   res_q;
  logic [SIZE-1:0][7:0]             row_res;
  logic                             last_row;

  assign last_row  = (row_q == ROW_W'(SIZE - 1));
  assign state_dbg = state_q;

  // One requantizer per column; the row counter selects which row of the
  // captured matrix feeds them this cycle.
  for (genvar c = 0; c < SIZE; c++) begin : g_col
    act_requant u_requant (
      .x     (cap_q[row_q][c]),
      .shift (shift_q),
      .y     (row_res[c])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_d       = state_q;
    acc_out_pop   = 1'b0;
    act_out_valid = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE: if (acc_out_rdy) state_d = POP;
      POP: begin
        acc_out_pop = 1'b1;
        state_d     = PROC;
      end
      PROC: if (last_row) state_d = OUT;
      OUT: begin
        act_out_valid = 1'b1;
        if (act_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on POP, accumulate rows in res_q during PROC, and
  // publish the whole matrix to act_out only on the final row so act_out
  // keeps the previous result until a new one is complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q   <= '0;
      cap_q   <= '0;
      shift_q <= '0;
      res_q   <= '0;
      act_out <= '0;
    end else begin
      case (state_q)
        POP: begin
          cap_q   <= acc_out;
          shift_q <= shift;
          row_q   <= '0;
        end
        PROC: begin
          res_q[row_q] <= row_res;
          if (last_row) begin
            row_q <= '0;
            for (int r = 0; r < SIZE; r++) begin
              act_out[r] <= (r == SIZE - 1) ? row_res : res_q[r];
            end
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_act_unit.sv
// Testbench for act_unit: a show-ahead source queue models the mmu FIFO,
// a scoreboard queue holds expected matrices computed by an arithmetic
// reference model, and directed scenarios are followed by a random run.
module tb_act_unit;
  import tpu_pkg::*;

  localparam int SIZE = 2;
  localparam int RW   = SIZE * SIZE * 8;

  typedef logic [SIZE-1:0][SIZE-1:0][31:0] mat_t;
  typedef logic [SIZE-1:0][SIZE-1:0][7:0]  res_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       acc_out_rdy = 1'b0;
  mat_t       acc_out = '0;
  logic [4:0] shift = '0;
  logic       act_out_ready = 1'b0;
  logic       acc_out_pop;
  res_t       act_out;
  logic       act_out_valid;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  act_unit #(.SIZE(SIZE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .acc_out_rdy   (acc_out_rdy),
    .acc_out       (acc_out),
    .acc_out_pop   (acc_out_pop),
    .shift         (shift),
    .act_out       (act_out),
    .act_out_valid (act_out_valid),
    .act_out_ready (act_out_ready),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  mat_t          src_q[$];
  logic [RW-1:0] last_act = '0;
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  pop_cycle = -100;
  int  pops = 0;
  int  xfers = 0;
  bit  in_flight = 0;
  bit  pending_pop = 0;
  bit  prev_idle = 1;
  bit  xfer_cand = 0;
  bit  rand_rdy = 0;
  bit  rand_shift = 0;
  bit  rand_ready = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // floor((x + half) / 2^s), then optional ReLU, then clamp.
  function automatic logic [7:0] ref_elem(input logic [31:0] x, input int s);
    longint v;
    longint d;
    longint n;
    longint q;
    logic [7:0] o;
    v = longint'($signed(x));
    d = longint'(1) << s;
    n = v + ((s > 0) ? d / 2 : 0);
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
`ifdef ACT_UNIT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    o = 8'(q);
    return o;
  endfunction

  function automatic logic [RW-1:0] ref_mat(input mat_t m, input int s);
    res_t r;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        r[i][j] = ref_elem(m[i][j], s);
    return r;
  endfunction

  function automatic mat_t mk_mat(input logic [31:0] a, b, c, d);
    mat_t m;
    m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
    return m;
  endfunction

  function automatic logic [RW-1:0] mk_res(input logic [7:0] a, b, c, d);
    res_t r;
    r[0][0] = a; r[0][1] = b; r[1][0] = c; r[1][1] = d;
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        case ($urandom_range(0, 3))
          0: m[i][j] = 32'($urandom_range(0, 600)) - 32'd300;
          1: m[i][j] = $urandom;
          2: m[i][j] = ($urandom_range(0, 1) != 0) ? 32'h7fff_ffff : 32'h8000_0000;
          default: m[i][j] = 32'($urandom_range(0, 70000)) - 32'd35000;
        endcase
    return m;
  endfunction

  // ---------------- per-cycle monitor + feeder ----------------
  // Events at the edge just passed (pop capture, transfer) are resolved
  // from the input values that edge saw, then this cycle's outputs are
  // checked, then inputs for the next edge are chosen.
  task automatic tick();
    mat_t junk;
    @(posedge clk);
    #1;
    cyc++;
    if (pending_pop) begin
      junk = src_q.pop_front();
      pending_pop = 0;
    end
    if (!rst_n) begin
      exp_q.delete();
      in_flight = 0;
      xfer_cand = 0;
      last_act  = '0;
      check("rst_pop", acc_out_pop, 0);
      check("rst_valid", act_out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_act_out", act_out, 0);
      check("rst_state", state_dbg, 64'(IDLE));
      prev_idle = 1;
    end else begin
      if (xfer_cand && act_out_ready) begin
        last_act  = exp_q.pop_front();
        in_flight = 0;
        xfers++;
      end
      check("pop", acc_out_pop, prev_idle && acc_out_rdy);
      if (acc_out_pop && src_q.size() > 0) begin
        check("pop_single", exp_q.size(), 0);
        exp_q.push_back(ref_mat(src_q[0], int'(shift)));
        pending_pop = 1;
        in_flight   = 1;
        pop_cycle   = cyc;
        pops++;
      end
      check("busy", busy, in_flight);
      check("valid", act_out_valid, in_flight && (cyc >= pop_cycle + 1 + SIZE));
      xfer_cand = 0;
      if (act_out_valid && exp_q.size() > 0) begin
        check("act_out", act_out, exp_q[0]);
        xfer_cand = 1;
      end else if (!act_out_valid) begin
        check("act_hold", act_out, last_act);
      end
      prev_idle = !in_flight;
    end
    // Drivers: hold acc_out and shift through the POP cycle.
    if (!pending_pop) begin
      if (rand_shift) shift = 5'($urandom_range(0, 31));
      if (src_q.size() > 0) acc_out = src_q[0];
      else acc_out = rand_mat();
    end
    acc_out_rdy = (src_q.size() > 0) && (!rand_rdy || ($urandom_range(0, 3) != 0));
    if (rand_ready) act_out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic run_until_xfers(input int target, input int budget);
    for (int i = 0; i < budget && xfers < target; i++) tick();
    check("xfer_budget", xfers >= target, 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int p0;
    int x0;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    act_out_ready = 1'b1;

    // Plain pass-through at shift 0, latency checked by the monitor.
    shift = 5'd0;
    src_q.push_back(mk_mat(32'h13, 32'h16, 32'h2B, 32'h32));
    run_until_xfers(1, 30);
    check("t_shift0", last_act, mk_res(8'h13, 8'h16, 8'h2B, 8'h32));

    // Same matrix, shift 1: half-up rounding.
    shift = 5'd1;
    src_q.push_back(mk_mat(32'h13, 32'h16, 32'h2B, 32'h32));
    run_until_xfers(2, 30);
    check("t_shift1", last_act, mk_res(8'd10, 8'd11, 8'd22, 8'd25));

    // Saturation and negative rounding.
    src_q.push_back(mk_mat(32'd1000, -32'sd1000, -32'sd3, -32'sd4));
    run_until_xfers(3, 30);
`ifdef ACT_UNIT_RELU_EN
    check("t_sat", last_act, mk_res(8'd127, 8'd0, 8'd0, 8'd0));
`else
    check("t_sat", last_act, mk_res(8'd127, 8'h80, 8'hFF, 8'hFE));
`endif

    // Downstream stall with more data waiting upstream.
    shift = 5'd3;
    act_out_ready = 1'b0;
    src_q.push_back(rand_mat());
    src_q.push_back(rand_mat());
    for (int i = 0; i < 20 && !act_out_valid; i++) tick();
    check("stall_valid_reached", act_out_valid, 1);
    p0 = pops;
    repeat (5) tick();
    check("stall_no_second_pop", pops, p0);
    check("stall_valid_held", act_out_valid, 1);
    act_out_ready = 1'b1;
    run_until_xfers(5, 40);

    // Reset in the middle of PROC discards the matrix in flight.
    src_q.push_back(rand_mat());
    src_q.push_back(rand_mat());
    p0 = pops;
    for (int i = 0; i < 20 && pops == p0; i++) tick();
    tick();
    check("rst_mid_in_proc", busy && !act_out_valid && !acc_out_pop, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_pop_resume", acc_out_pop, 1);
    run_until_xfers(6, 30);

    // Back-to-back matrices.
    x0 = xfers;
    p0 = pops;
    shift = 5'd2;
    src_q.push_back(rand_mat());
    src_q.push_back(rand_mat());
    run_until_xfers(x0 + 2, 40);
    check("b2b_pops", pops - p0, 2);

    // Random traffic: shift, upstream readiness and downstream ready vary.
    rand_rdy   = 1;
    rand_shift = 1;
    rand_ready = 1;
    x0 = xfers;
    for (int k = 0; k < 25; k++) src_q.push_back(rand_mat());
    run_until_xfers(x0 + 25, 3000);
    check("rand_src_drained", src_q.size(), 0);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
